// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer: owns the PC, reads a 1-cycle-latency IMEM and
// hands each word to decode over a valid/accept handshake, resolving BEQ branches at accept.
module instr_fetch_unit #(
    parameter int unsigned IMEM_DEPTH = 64,
    parameter int unsigned IMEM_AW    = 6,
    parameter logic [31:0] PC_RESET   = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    output logic               IMEM_RE,
    output logic [IMEM_AW-1:0] IMEM_ADDR,
    input  logic [31:0]        IMEM_RDATA,
    output logic [31:0]        INSTR,
    output logic [5:0]         Instruction,
    output logic [5:0]         Funct,
    output logic               INSTR_VALID,
    input  logic               INSTR_ACCEPT,
    input  logic               BRANCH,
    input  logic               ZERO,
    output logic [31:0]        PC,
    output logic [31:0]        PC_PLUS4,
    output logic               HALTED,
    output logic               FAULT
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StIssue,
        StHalt
    } state_e;

    localparam logic [5:0] HaltOpcode = 6'b111111;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        halted_q, halted_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    function automatic logic in_range(input logic [31:0] addr);
        return ({2'b00, addr[31:2]} < IMEM_DEPTH);
    endfunction

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign next_pc       = (BRANCH && ZERO) ? branch_target : pc_plus4;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        unique case (state_q)
            StIdle: begin
                if (EN) begin
                    if (in_range(pc_q)) begin
                        state_d = StReq;
                    end else begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end
                end
            end
            StReq: state_d = StWait;
            StWait: begin
                // A halt word is never issued, so INSTR keeps the previous instruction.
                if (IMEM_RDATA[31:26] == HaltOpcode) begin
                    state_d  = StHalt;
                    halted_d = 1'b1;
                end else begin
                    instr_d = IMEM_RDATA;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (INSTR_ACCEPT) begin
                    pc_d = next_pc;
                    if (!EN) begin
                        state_d = StIdle;
                    end else if (in_range(next_pc)) begin
                        state_d = StReq;
                    end else begin
                        state_d = StHalt;
                        fault_d = 1'b1;
                    end
                end
            end
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            pc_q     <= PC_RESET;
            instr_q  <= 32'h0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign IMEM_RE     = (state_q == StReq);
    assign IMEM_ADDR   = pc_q[IMEM_AW+1:2];
    assign INSTR       = instr_q;
    assign Instruction = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign INSTR_VALID = (state_q == StIssue);
    assign PC          = pc_q;
    assign PC_PLUS4    = pc_plus4;
    assign HALTED      = halted_q;
    assign FAULT       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, branches, backpressure, halt,
// fault and reset during an in-flight read, against a behavioural 1-cycle IMEM.
module tb_instr_fetch_unit;

    localparam logic [31:0] WAdd  = 32'h0109_5020;
    localparam logic [31:0] WSub  = 32'h0109_5022;
    localparam logic [31:0] WAnd  = 32'h0109_5024;
    localparam logic [31:0] WBeqB = 32'h1000_FFFC;
    localparam logic [31:0] WBeqF = 32'h1000_0100;
    localparam logic [31:0] WHalt = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        RST, EN, INSTR_ACCEPT, BRANCH, ZERO;
    logic        IMEM_RE, INSTR_VALID, HALTED, FAULT;
    logic [5:0]  IMEM_ADDR, Instruction, Funct;
    logic [31:0] IMEM_RDATA, INSTR, PC, PC_PLUS4;
    logic [31:0] mem [64];

    int n_checks = 0;
    int n_errors = 0;

    instr_fetch_unit #(
        .IMEM_DEPTH(64),
        .IMEM_AW   (6),
        .PC_RESET  (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .EN          (EN),
        .IMEM_RE     (IMEM_RE),
        .IMEM_ADDR   (IMEM_ADDR),
        .IMEM_RDATA  (IMEM_RDATA),
        .INSTR       (INSTR),
        .Instruction (Instruction),
        .Funct       (Funct),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_ACCEPT(INSTR_ACCEPT),
        .BRANCH      (BRANCH),
        .ZERO        (ZERO),
        .PC          (PC),
        .PC_PLUS4    (PC_PLUS4),
        .HALTED      (HALTED),
        .FAULT       (FAULT)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (IMEM_RE) IMEM_RDATA <= mem[IMEM_ADDR];
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered in the REQ cycle; leaves one cycle after the accept edge.
    task automatic issue_one(input logic [31:0] pc, input logic [31:0] word, input int stall,
                             input logic br, input logic zr, input logic en_acc);
        check_eq("req_re", {31'b0, IMEM_RE}, 32'd1);
        check_eq("req_addr", {26'b0, IMEM_ADDR}, {26'b0, pc[7:2]});
        check_eq("req_valid", {31'b0, INSTR_VALID}, 32'd0);
        step();
        check_eq("wait_re", {31'b0, IMEM_RE}, 32'd0);
        check_eq("wait_valid", {31'b0, INSTR_VALID}, 32'd0);
        step();
        check_eq("iss_valid", {31'b0, INSTR_VALID}, 32'd1);
        check_eq("iss_pc", PC, pc);
        check_eq("iss_pc4", PC_PLUS4, pc + 32'd4);
        check_eq("iss_instr", INSTR, word);
        check_eq("iss_opc", {26'b0, Instruction}, {26'b0, word[31:26]});
        check_eq("iss_funct", {26'b0, Funct}, {26'b0, word[5:0]});
        BRANCH = 1'b1;
        ZERO   = 1'b1;
        for (int i = 0; i < stall; i++) begin
            step();
            check_eq("bp_valid", {31'b0, INSTR_VALID}, 32'd1);
            check_eq("bp_re", {31'b0, IMEM_RE}, 32'd0);
            check_eq("bp_pc", PC, pc);
            check_eq("bp_instr", INSTR, word);
            check_eq("bp_funct", {26'b0, Funct}, {26'b0, word[5:0]});
        end
        BRANCH       = br;
        ZERO         = zr;
        EN           = en_acc;
        INSTR_ACCEPT = 1'b1;
        step();
        INSTR_ACCEPT = 1'b0;
        BRANCH       = 1'b0;
        ZERO         = 1'b0;
        check_eq("acc_valid", {31'b0, INSTR_VALID}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        IMEM_RDATA = 32'h0;
        mem[0] = WAdd; mem[1] = WSub; mem[2] = WAnd; mem[3] = WAdd; mem[4] = WBeqB;
        mem[5] = WAdd; mem[6] = WSub;
        RST = 1'b1; EN = 1'b0; INSTR_ACCEPT = 1'b0; BRANCH = 1'b0; ZERO = 1'b0;
        step();
        step();
        RST = 1'b0;
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_instr", INSTR, 32'h0);
        check_eq("rst_opc", {26'b0, Instruction}, 32'h0);
        check_eq("rst_funct", {26'b0, Funct}, 32'h0);
        check_eq("rst_valid", {31'b0, INSTR_VALID}, 32'd0);
        check_eq("rst_re", {31'b0, IMEM_RE}, 32'd0);
        check_eq("rst_halted", {31'b0, HALTED}, 32'd0);
        check_eq("rst_fault", {31'b0, FAULT}, 32'd0);
        INSTR_ACCEPT = 1'b1;
        step();
        INSTR_ACCEPT = 1'b0;
        check_eq("idle_re", {31'b0, IMEM_RE}, 32'd0);
        check_eq("idle_pc", PC, 32'h0);
        EN = 1'b1;
        step();

        // Sequential fetch, then a taken backward branch at 0x10.
        issue_one(32'h00, WAdd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h04, WSub, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h08, WAnd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h0C, WAdd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h10, WBeqB, 0, 1'b1, 1'b1, 1'b1);
        check_eq("beq_taken_pc", PC, 32'h04);
        issue_one(32'h04, WSub, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h08, WAnd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h0C, WAdd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h10, WBeqB, 0, 1'b1, 1'b0, 1'b1);
        check_eq("beq_not_taken_pc", PC, 32'h14);

        // Backpressure for 4 cycles, then accept with EN=0 parks in IDLE.
        issue_one(32'h14, WAdd, 4, 1'b0, 1'b0, 1'b0);
        check_eq("en0_re", {31'b0, IMEM_RE}, 32'd0);
        step();
        check_eq("en0_idle_re", {31'b0, IMEM_RE}, 32'd0);
        check_eq("en0_pc", PC, 32'h18);
        EN = 1'b1;
        step();
        issue_one(32'h18, WSub, 0, 1'b0, 1'b0, 1'b1);

        // Halt word at PC=8.
        mem[2] = WHalt;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("rst2_pc", PC, 32'h0);
        check_eq("rst2_instr", INSTR, 32'h0);
        step();
        issue_one(32'h00, WAdd, 0, 1'b0, 1'b0, 1'b1);
        issue_one(32'h04, WSub, 0, 1'b0, 1'b0, 1'b1);
        check_eq("halt_req_re", {31'b0, IMEM_RE}, 32'd1);
        check_eq("halt_req_addr", {26'b0, IMEM_ADDR}, 32'd2);
        step();
        check_eq("halt_wait_halted", {31'b0, HALTED}, 32'd0);
        step();
        check_eq("halt_halted", {31'b0, HALTED}, 32'd1);
        check_eq("halt_valid", {31'b0, INSTR_VALID}, 32'd0);
        check_eq("halt_instr_kept", INSTR, WSub);
        for (int i = 0; i < 4; i++) begin
            EN = ~EN;
            INSTR_ACCEPT = 1'b1;
            step();
            check_eq("halt_hold", {29'b0, HALTED, IMEM_RE, INSTR_VALID}, 32'b100);
        end
        INSTR_ACCEPT = 1'b0;

        // Forward branch leaves the memory -> FAULT.
        mem[0] = WBeqF;
        EN  = 1'b1;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("rst3_pc", PC, 32'h0);
        check_eq("rst3_halted", {31'b0, HALTED}, 32'd0);
        step();
        issue_one(32'h00, WBeqF, 0, 1'b1, 1'b1, 1'b1);
        check_eq("fault_flag", {31'b0, FAULT}, 32'd1);
        check_eq("fault_pc", PC, 32'h404);
        check_eq("fault_halted", {31'b0, HALTED}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("fault_hold", {30'b0, FAULT, IMEM_RE}, 32'b10);
        end

        // Reset while a read is in flight.
        mem[0] = WAdd;
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("rst4_fault", {31'b0, FAULT}, 32'd0);
        step();
        issue_one(32'h00, WAdd, 0, 1'b0, 1'b0, 1'b1);
        step();
        check_eq("mid_wait_instr", INSTR, WAdd);
        RST = 1'b1;
        step();
        RST = 1'b0;
        check_eq("mid_instr", INSTR, 32'h0);
        check_eq("mid_pc", PC, 32'h0);
        check_eq("mid_valid", {31'b0, INSTR_VALID}, 32'd0);
        check_eq("mid_re", {31'b0, IMEM_RE}, 32'd0);
        step();
        issue_one(32'h00, WAdd, 0, 1'b0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch and issue sequencer that sits in front of Control_Unit. It owns the PC and reads a synchronous instruction memory with 1-cycle read latency. It presents each fetched word to the decode side with a valid/accept handshake, driving the Instruction and Funct fields that Control_Unit consumes. It resolves BEQ-style branches from the datapath's Branch/Zero feedback when it computes the next PC.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words; must be a power of 2.
IMEM_AW, 6, word-address width; equals log2(IMEM_DEPTH).
PC_RESET, 32'h0000_0000, PC value after reset; word-aligned.

Ports:
CLK  in  1  single clock, rising edge.
RST  in  1  synchronous, active-high reset.
EN  in  1  run enable; sampled only in IDLE and on the accept cycle.
IMEM_RE  out  1  read strobe to instruction memory.
IMEM_ADDR  out  IMEM_AW  word address, equal to PC[IMEM_AW+1:2].
IMEM_RDATA  in  32  read data, valid one cycle after the IMEM_RE cycle.
INSTR  out  32  issued instruction word.
Instruction  out  6  INSTR[31:26], the opcode to Control_Unit.
Funct  out  6  INSTR[5:0], to Control_Unit.
INSTR_VALID  out  1  INSTR, PC and PC_PLUS4 are valid.
INSTR_ACCEPT  in  1  decode/execute consumes the instruction this cycle.
BRANCH  in  1  Branch output from Control_Unit for the issued instruction.
ZERO  in  1  ALU zero flag for the issued instruction.
PC  out  32  address of the issued/pending instruction.
PC_PLUS4  out  32  PC + 4, combinational from PC.
HALTED  out  1  halt instruction reached.
FAULT  out  1  PC outside the instruction memory.

Behaviour:
- Reset (RST=1 at an edge, from any state): state=IDLE, PC=PC_RESET, INSTR=0, INSTR_VALID=0, IMEM_RE=0, HALTED=0, FAULT=0. Any in-flight IMEM read is discarded.
- Instruction and Funct are always combinational slices of INSTR, so both are 0 after reset.
- The FSM has states IDLE, REQ, WAIT, ISSUE, HALT.
- IDLE: all outputs held.
  - EN=1 and PC[31:2] < IMEM_DEPTH: go to REQ.
  - EN=1 and PC out of range: go to HALT with FAULT=1.
- REQ: IMEM_RE=1 and IMEM_ADDR=PC for exactly one cycle, then go to WAIT.
- WAIT: IMEM_RDATA is valid this cycle.
  - If IMEM_RDATA[31:26]==6'b111111 (halt): INSTR is not loaded, go to HALT, HALTED=1.
  - Otherwise INSTR<=IMEM_RDATA and go to ISSUE.
- ISSUE: INSTR_VALID=1. INSTR, PC and PC_PLUS4 stay stable until INSTR_ACCEPT=1; there is no timeout.
- On the accept cycle:
  - BRANCH and ZERO are sampled in this same cycle.
  - If BRANCH & ZERO: PC <= PC_PLUS4 + {{14{INSTR[15]}}, INSTR[15:0], 2'b00}.
  - Otherwise: PC <= PC_PLUS4.
  - All PC arithmetic is 32-bit and wraps modulo 2^32.
  - INSTR_VALID drops on the next cycle.
- Next state after accept:
  - New PC in range and EN=1: REQ.
  - EN=0: IDLE.
  - New PC out of range: HALT with FAULT=1. The range check is done on the new PC.
- HALT: INSTR_VALID=0, IMEM_RE=0. HALTED or FAULT stays asserted. Only RST leaves this state.
- Timing:
  - Latency from the REQ cycle to INSTR_VALID=1 is 2 cycles.
  - Best-case throughput is 1 instruction per 3 cycles, with accept in the first ISSUE cycle.
  - IMEM_RE is never asserted outside REQ.
- EN=0 while in REQ or WAIT does not abort the fetch; it takes effect at accept.
- BRANCH and ZERO are ignored outside the accept cycle.
- INSTR_ACCEPT is ignored when INSTR_VALID=0.

Test Plan:
- Sequential fetch: reset, EN=1, IMEM holds ADD at 0, SUB at 4, AND at 8; accept on every first ISSUE cycle -> IMEM_ADDR 0, 1, 2; PC 0, 4, 8; Instruction=0, Funct=0x20/0x22/0x24; INSTR_VALID high 1 cycle in every 3.
- Branch taken, backward: BEQ at PC=0x10 with imm=16'hFFFC, BRANCH=1, ZERO=1 at accept -> next PC=0x04 and IMEM_ADDR=1. Repeat with ZERO=0 -> next PC=0x14.
- Backpressure: hold INSTR_ACCEPT=0 for 4 cycles in ISSUE -> INSTR, PC and Funct unchanged, INSTR_VALID stays 1, IMEM_RE stays 0; accept on the 5th cycle -> advance.
- Halt: word 0xFC000000 at PC=8 -> HALTED=1 two cycles after the REQ for address 2; INSTR_VALID never asserts for it; EN toggling has no effect; RST returns PC=0.
- Fault: IMEM_DEPTH=64, BEQ at PC=0 with imm=16'h0100 taken -> new PC=0x404 is out of range -> FAULT=1, no further IMEM_RE.
- Reset mid-operation: assert RST during WAIT -> next cycle state=IDLE, INSTR=0, INSTR_VALID=0, PC=PC_RESET, the returned IMEM_RDATA is discarded.
